fifo_wr_splitter: RTL and testbench
===================================

Name: fifo_wr_splitter

Overview:
Write-side feeder for the synchronous FIFO. It accepts wide words with a valid/ready handshake and emits them as a sequence of FIFO-width beats, LSB lane first, on the FIFO write port. It honours the FIFO full flag by holding the current beat until it is written. It sits in the wr_clk domain, directly upstream of the FIFO write interface.

Parameters:
IN_WIDTH, 32, width of the upstream word; must be RATIO*OUT_WIDTH.
OUT_WIDTH, 8, FIFO data width (beat width).
RATIO, 4, lanes per word; must be a power of 2 and at least 2.
LANE_W, 2, log2(RATIO); width of the lane index and of in_last_lane.
CNT_W, 16, width of the beat statistics counter.

Ports:
wr_clk  input  1  write-side clock; all state on posedge.
wr_rstn  input  1  reset, asynchronous, active-low.
in_valid  input  1  upstream word valid.
in_ready  output  1  splitter can accept a word this cycle.
in_data  input  IN_WIDTH  upstream word; lane k = in_data[k*OUT_WIDTH +: OUT_WIDTH].
in_last_lane  input  LANE_W  index of the last valid lane (0 means 1 beat, RATIO-1 means RATIO beats).
fifo_full  input  1  FIFO full flag.
fifo_wr_valid  output  1  beat valid to FIFO (connects to FIFO wr_valid).
fifo_wr_data  output  OUT_WIDTH  beat data to FIFO (connects to FIFO wr_data).
busy  output  1  high while a word is being split.
beat_cnt  output  CNT_W  saturating count of beats written into the FIFO.
clr_cnt  input  1  synchronous clear of beat_cnt.

Behaviour:
- Reset (wr_rstn low, asynchronous): state=IDLE. Word register, lane_idx and last_idx = 0. fifo_wr_valid=0, fifo_wr_data=0, busy=0, beat_cnt=0.
  - in_ready is 1 in IDLE, so it reads 1 during and after reset.
- States: IDLE, SEND.
- Definitions:
  - Word accept: in_valid && in_ready.
  - Beat write: fifo_wr_valid && !fifo_full. This is the FIFO's own w_en condition.
  - last_beat: beat write && (lane_idx == last_idx).
- IDLE:
  - in_ready=1, fifo_wr_valid=0.
  - On word accept: latch in_data and in_last_lane into last_idx, set lane_idx=0, go to SEND.
- SEND:
  - fifo_wr_valid=1. fifo_wr_data = latched lane[lane_idx], driven from registers only.
  - Beat write with lane_idx < last_idx: lane_idx+1.
  - fifo_full=1: no beat write. lane_idx, data and fifo_wr_valid hold stable; no beat is lost or duplicated.
  - last_beat:
    - If in_valid=1, accept the next word in the same cycle, reload, lane_idx=0, stay in SEND. Back-to-back words give no bubble.
    - Else go to IDLE.
- in_ready = (state==IDLE) || last_beat. This is combinational from fifo_full; no other combinational in-to-out path exists.
- Latency: word accepted in cycle N produces its first beat on fifo_wr_valid in N+1. With no back-pressure, a word of L lanes occupies exactly L cycles.
- Throughput: 1 beat/cycle when fifo_full=0.
- busy = (state==SEND).
- beat_cnt:
  - Increments by 1 on each beat write.
  - Saturates at all-ones, with no wrap.
  - clr_cnt=1 sets it to 0 and has priority over a same-cycle increment.
- in_data and in_last_lane are sampled only on word accept. Changes while in_ready=0 are ignored.
- Upstream must hold in_valid and in_data until accepted. The splitter never drops a presented word.
- fifo_full toggling every cycle: beats advance only on cycles with fifo_full=0. Order is preserved.
- Asynchronous reset mid-word: the partial word is discarded. fifo_wr_valid drops immediately. No further beats of that word are emitted after reset release.

Test Plan:
- Single full word: in_data=0xDDCCBBAA, in_last_lane=3, fifo_full=0 -> fifo_wr_valid high 4 cycles starting N+1 with data AA,BB,CC,DD; in_ready high again in the cycle of the DD write; beat_cnt=4.
- Partial word: in_data=0x44332211, in_last_lane=1 -> exactly 2 beats, 11 then 22; state back to IDLE; beat_cnt=2.
- Back-to-back: two words 0x03020100 and 0x07060504, both in_last_lane=3, in_valid held -> 8 consecutive beats 00..07 with no idle cycle; second word accepted in the cycle of beat 03.
- Back-pressure: fifo_full=1 for 3 cycles while lane 1 (0xBB) is presented -> fifo_wr_valid=1 and data=BB held stable for 3 cycles; BB written exactly once after full drops; total beats still 4, order AA,BB,CC,DD.
- Reset mid-word: assert wr_rstn low after 2 beats of 0xDDCCBBAA -> fifo_wr_valid=0 and beat_cnt=0 immediately; after release in_ready=1 and no CC/DD beats appear.
- Counter: preload by running 2^CNT_W-1 beats (or a CNT_W=4 build with 15 beats), then 2 more beats -> beat_cnt stays 0xF; clr_cnt coincident with a beat write -> beat_cnt=0.

Source files
------------

// File: rtl/fifo_wr_splitter.sv
// ---------------------------------------------------------------------------
// fifo_wr_splitter
//
// Write-side feeder for the synchronous FIFO. Accepts wide words on a
// valid/ready handshake and emits them as FIFO-width beats, lowest lane
// first, on the FIFO write port. A beat is held stable while the FIFO is
// full, so no beat is ever lost or duplicated.
//
// Ports:
//   wr_clk         write-side clock, all state on the rising edge
//   wr_rstn        asynchronous active-low reset
//   in_valid       upstream word valid
//   in_ready       splitter can take a word this cycle
//   in_data        upstream word, lane k = in_data[k*OUT_WIDTH +: OUT_WIDTH]
//   in_last_lane   index of the last valid lane (0 = one beat)
//   fifo_full      FIFO full flag
//   fifo_wr_valid  beat valid to the FIFO
//   fifo_wr_data   beat data to the FIFO
//   busy           a word is being split
//   beat_cnt       saturating count of beats written into the FIFO
//   clr_cnt        synchronous clear of beat_cnt (wins over an increment)
// ---------------------------------------------------------------------------
module fifo_wr_splitter #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4,
    parameter int LANE_W    = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 wr_clk,
    input  logic                 wr_rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [LANE_W-1:0]    in_last_lane,
    input  logic                 fifo_full,
    output logic                 fifo_wr_valid,
    output logic [OUT_WIDTH-1:0] fifo_wr_data,
    output logic                 busy,
    output logic [CNT_W-1:0]     beat_cnt,
    input  logic                 clr_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   word_q,  word_d;
    logic [LANE_W-1:0]     lane_q,  lane_d;
    logic [LANE_W-1:0]     last_q,  last_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;

    logic [OUT_WIDTH-1:0]  lanes [RATIO];
    logic                  beat_write;
    logic                  last_beat;
    logic                  accept;

    // Slice the latched word into lanes so the beat mux indexes by lane.
    for (genvar k = 0; k < RATIO; k++) begin : g_lanes
        assign lanes[k] = word_q[k*OUT_WIDTH +: OUT_WIDTH];
    end

    // Beat write mirrors the FIFO's own write-enable; the final beat of a
    // word frees the splitter in the same cycle so words can chain.
    assign beat_write    = (state_q == SEND) && !fifo_full;
    assign last_beat     = beat_write && (lane_q == last_q);
    assign in_ready      = (state_q == IDLE) || last_beat;
    assign accept        = in_valid && in_ready;

    assign fifo_wr_valid = (state_q == SEND);
    assign fifo_wr_data  = lanes[lane_q];
    assign busy          = (state_q == SEND);
    assign beat_cnt      = cnt_q;

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            state_q <= IDLE;
            word_q  <= '0;
            lane_q  <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. A word is loaded whenever it is accepted, whether
    // from IDLE or on the last beat of the previous word.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        lane_d  = lane_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_beat) begin
                    state_d = in_valid ? SEND : IDLE;
                end else if (beat_write) begin
                    lane_d = lane_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            word_d = in_data;
            last_d = in_last_lane;
            lane_d = '0;
        end
    end

    // Beat counter saturates at all-ones; clear takes priority.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (beat_write && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_splitter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_splitter
//
// Self-checking bench for fifo_wr_splitter. A queue of pending beats plus a
// saturating count stands in for the expected behaviour; every cycle the
// DUT outputs are compared against it. A narrow counter build makes
// saturation reachable in a handful of beats.
// ---------------------------------------------------------------------------
module tb_fifo_wr_splitter;

    localparam int IN_WIDTH  = 32;
    localparam int OUT_WIDTH = 8;
    localparam int RATIO     = 4;
    localparam int LANE_W    = 2;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = 15;

    logic                 wr_clk;
    logic                 wr_rstn;
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic [LANE_W-1:0]    in_last_lane;
    logic                 fifo_full;
    logic                 fifo_wr_valid;
    logic [OUT_WIDTH-1:0] fifo_wr_data;
    logic                 busy;
    logic [CNT_W-1:0]     beat_cnt;
    logic                 clr_cnt;

    int numChecks;
    int numErrors;

    logic [7:0] expQ[$];
    int         expCnt;
    logic       accepted;

    fifo_wr_splitter #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .RATIO    (RATIO),
        .LANE_W   (LANE_W),
        .CNT_W    (CNT_W)
    ) dut (
        .wr_clk       (wr_clk),
        .wr_rstn      (wr_rstn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last_lane (in_last_lane),
        .fifo_full    (fifo_full),
        .fifo_wr_valid(fifo_wr_valid),
        .fifo_wr_data (fifo_wr_data),
        .busy         (busy),
        .beat_cnt     (beat_cnt),
        .clr_cnt      (clr_cnt)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare at the falling edge against the
    // beat queue, then advance the queue the way the FIFO would see it.
    task automatic applyStimulus(input logic v, input logic [31:0] d,
                                 input logic [1:0] l, input logic f,
                                 input logic c);
        logic expValid;
        logic expReady;
        in_valid     = v;
        in_data      = d;
        in_last_lane = l;
        fifo_full    = f;
        clr_cnt      = c;
        @(negedge wr_clk);
        expValid = (expQ.size() != 0);
        expReady = !expValid || ((expQ.size() == 1) && !f);
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
        checkOutput("wr_valid", {31'd0, fifo_wr_valid}, {31'd0, expValid});
        checkOutput("busy", {31'd0, busy}, {31'd0, expValid});
        checkOutput("beat_cnt", {28'd0, beat_cnt}, expCnt);
        if (expValid) begin
            checkOutput("wr_data", {24'd0, fifo_wr_data}, {24'd0, expQ[0]});
        end
        if (expValid && !f) begin
            void'(expQ.pop_front());
            if (expCnt < CNT_MAX) expCnt++;
        end
        if (c) expCnt = 0;
        accepted = v && expReady;
        if (accepted) begin
            for (int k = 0; k <= int'(l); k++) begin
                expQ.push_back(d[k*8 +: 8]);
            end
        end
        @(posedge wr_clk);
        #1;
    endtask

    // Present a word and hold it until taken, with a bounded wait.
    task automatic sendWord(input logic [31:0] d, input logic [1:0] l);
        int tries;
        tries = 0;
        accepted = 1'b0;
        while (!accepted && tries < 16) begin
            applyStimulus(1'b1, d, l, 1'b0, 1'b0);
            tries++;
        end
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic        haveWord;
        logic [31:0] rWord;
        logic [1:0]  rLast;
        numChecks    = 0;
        numErrors    = 0;
        expCnt       = 0;
        accepted     = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_last_lane = '0;
        fifo_full    = 1'b0;
        clr_cnt      = 1'b0;
        wr_rstn      = 1'b0;

        // Reset values, checked while reset is held.
        #2;
        checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_valid", {31'd0, fifo_wr_valid}, 32'd0);
        checkOutput("rst_data", {24'd0, fifo_wr_data}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_cnt", {28'd0, beat_cnt}, 32'd0);
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        wr_rstn = 1'b1;
        @(posedge wr_clk);
        #1;

        // Single full word.
        sendWord(32'hDDCCBBAA, 2'd3);
        idleCycles(4);
        checkOutput("single_cnt", {28'd0, beat_cnt}, 32'd4);

        // Partial word: two beats then idle.
        sendWord(32'h44332211, 2'd1);
        idleCycles(3);
        checkOutput("partial_cnt", {28'd0, beat_cnt}, 32'd6);
        checkOutput("partial_idle", {31'd0, busy}, 32'd0);

        // Back-to-back words with in_valid held: no bubble.
        sendWord(32'h03020100, 2'd3);
        sendWord(32'h07060504, 2'd3);
        idleCycles(5);

        // Back-pressure while lane 1 is presented.
        applyStimulus(1'b1, 32'hDDCCBBAA, 2'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        repeat (3) begin
            applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
            checkOutput("bp_hold_data", {24'd0, fifo_wr_data}, 32'hBB);
        end
        idleCycles(4);

        // Reset in the middle of a word.
        applyStimulus(1'b1, 32'hDDCCBBAA, 2'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        wr_rstn = 1'b0;
        #1;
        checkOutput("mid_rst_valid", {31'd0, fifo_wr_valid}, 32'd0);
        checkOutput("mid_rst_cnt", {28'd0, beat_cnt}, 32'd0);
        checkOutput("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        expQ.delete();
        expCnt = 0;
        #2;
        wr_rstn = 1'b1;
        idleCycles(4);

        // Saturation: 17 beats into a 4-bit counter.
        repeat (4) sendWord(32'h5A5A5A5A, 2'd3);
        sendWord(32'h000000C3, 2'd0);
        idleCycles(5);
        checkOutput("sat_cnt", {28'd0, beat_cnt}, 32'd15);

        // Clear coincident with a beat write.
        sendWord(32'h0000EE11, 2'd1);
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
        checkOutput("clr_prio_cnt", {28'd0, beat_cnt}, 32'd0);
        idleCycles(2);
        checkOutput("after_clr_cnt", {28'd0, beat_cnt}, 32'd1);

        // Randomized traffic with back-pressure and occasional clears.
        haveWord = 1'b0;
        rWord    = '0;
        rLast    = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!haveWord && ($urandom_range(0, 2) != 0)) begin
                haveWord = 1'b1;
                rWord    = $urandom;
                rLast    = 2'($urandom_range(0, 3));
            end
            applyStimulus(haveWord, rWord, rLast,
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 31) == 0));
            if (accepted) haveWord = 1'b0;
        end
        idleCycles(6);

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
        $finish;
    end

endmodule
